// File: rtl/aes_job_sched.sv
// aes_job_sched: shares one byte-serial AES-8 core between requesters A and B.
// A job is 16 {key,data} byte pairs. The pairs are buffered first and then
// replayed to the core on 16 back-to-back cycles, because the core cannot
// stall while loading. The 16 result bytes are forwarded tagged with the owner.
// Every output is a register, computed from the next-state decode.
module aes_job_sched #(
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_vld,
    input  logic [7:0] a_key,
    input  logic [7:0] a_din,
    output logic       a_rdy,
    input  logic       b_vld,
    input  logic [7:0] b_key,
    input  logic [7:0] b_din,
    output logic       b_rdy,
    output logic       core_rst,
    output logic [7:0] core_key,
    output logic [7:0] core_din,
    input  logic [7:0] core_dout,
    input  logic       core_dvld,
    output logic [7:0] out_byte,
    output logic       out_vld,
    output logic       out_id,
    output logic       job_done,
    output logic       job_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ZERO  = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_CRST  = 3'd2;
    localparam logic [2:0] ST_FEED  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    // Control state (grant: 0=A, 1=B; last_r holds the last-served requester)
    logic [2:0]       state_r, state_nxt_s;
    logic [3:0]       cnt_r, cnt_nxt_s;
    logic [TMO_W-1:0] tmo_r, tmo_nxt_s;
    logic             grant_r, grant_nxt_s;
    logic             last_r, last_nxt_s;
    logic             err_s;

    // Job buffer; its contents are only meaningful after a complete FILL
    logic [7:0] key_mem_r [16];
    logic [7:0] din_mem_r [16];

    // Registered outputs
    logic       a_rdy_r, b_rdy_r, core_rst_r;
    logic [7:0] core_key_r, core_din_r, out_byte_r;
    logic       out_vld_r, out_id_r, job_done_r, job_err_r;

    // Handshake and byte selection for the granted requester
    logic       hs_s;
    logic       fill_wr_s;
    logic [7:0] sel_key_s, sel_din_s;

    assign hs_s      = grant_r ? (b_vld & b_rdy_r) : (a_vld & a_rdy_r);
    assign fill_wr_s = (state_r == ST_FILL) & hs_s;
    assign sel_key_s = grant_r ? b_key : a_key;
    assign sel_din_s = grant_r ? b_din : a_din;

    // Next-state, counter, grant and last-served decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        tmo_nxt_s   = tmo_r;
        grant_nxt_s = grant_r;
        last_nxt_s  = last_r;
        err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (a_vld | b_vld) begin
                    state_nxt_s = ST_FILL;
                    cnt_nxt_s   = 4'd0;
                    if (a_vld & b_vld) begin
                        grant_nxt_s = ~last_r;
                    end else begin
                        grant_nxt_s = b_vld;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (hs_s) begin
                    cnt_nxt_s = cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        state_nxt_s = ST_CRST;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_CRST: begin
                state_nxt_s = ST_FEED;
                cnt_nxt_s   = 4'd0;
            end
            ST_FEED: begin
                cnt_nxt_s = cnt_r + 4'd1;
                if (cnt_r == 4'd15) begin
                    state_nxt_s = ST_WAIT;
                    tmo_nxt_s   = TMO_ZERO;
                end else begin
                    state_nxt_s = ST_FEED;
                end
            end
            ST_WAIT: begin
                tmo_nxt_s = tmo_r + TMO_ONE;
                if (core_dvld) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = 4'd0;
                end else if (tmo_nxt_s == TMO_LIMIT) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = grant_r;
                    err_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                cnt_nxt_s = cnt_r + 4'd1;
                if (cnt_r == 4'd15) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = grant_r;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Control registers; the last-served pointer resets to B so A wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            tmo_r   <= TMO_ZERO;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            tmo_r   <= tmo_nxt_s;
            grant_r <= grant_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Job buffer write on each FILL handshake; no reset, stale data is never replayed
    always_ff @(posedge clk) begin
        if (fill_wr_s) begin
            key_mem_r[cnt_r] <= sel_key_s;
            din_mem_r[cnt_r] <= sel_din_s;
        end
    end

    // Output registers, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdy_r    <= 1'b0;
            b_rdy_r    <= 1'b0;
            core_rst_r <= 1'b1;
            core_key_r <= 8'h00;
            core_din_r <= 8'h00;
            out_byte_r <= 8'h00;
            out_vld_r  <= 1'b0;
            out_id_r   <= 1'b0;
            job_done_r <= 1'b0;
            job_err_r  <= 1'b0;
        end else begin
            a_rdy_r    <= (state_nxt_s == ST_FILL) & ~grant_nxt_s;
            b_rdy_r    <= (state_nxt_s == ST_FILL) & grant_nxt_s;
            core_rst_r <= (state_nxt_s == ST_IDLE) | (state_nxt_s == ST_FILL) |
                          (state_nxt_s == ST_CRST);
            core_key_r <= (state_nxt_s == ST_FEED) ? key_mem_r[cnt_nxt_s] : 8'h00;
            core_din_r <= (state_nxt_s == ST_FEED) ? din_mem_r[cnt_nxt_s] : 8'h00;
            out_byte_r <= (state_nxt_s == ST_DRAIN) ? core_dout : 8'h00;
            out_vld_r  <= (state_nxt_s == ST_DRAIN);
            out_id_r   <= ((state_nxt_s == ST_DRAIN) | err_s) ? grant_r : out_id_r;
            job_done_r <= (state_nxt_s == ST_DRAIN) & (cnt_nxt_s == 4'd15);
            job_err_r  <= err_s;
        end
    end

    assign a_rdy    = a_rdy_r;
    assign b_rdy    = b_rdy_r;
    assign core_rst = core_rst_r;
    assign core_key = core_key_r;
    assign core_din = core_din_r;
    assign out_byte = out_byte_r;
    assign out_vld  = out_vld_r;
    assign out_id   = out_id_r;
    assign job_done = job_done_r;
    assign job_err  = job_err_r;

endmodule

// File: tb/tb_aes_job_sched.sv
// Directed bench for aes_job_sched. A small core model captures the 16 fed
// bytes and, after a programmable delay, returns key[i]^0xA0 for i=0..15.
module tb_aes_job_sched;

    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_vld, b_vld;
    logic [7:0] a_key, a_din, b_key, b_din;
    logic       a_rdy, b_rdy;
    logic       core_rst;
    logic [7:0] core_key, core_din;
    logic [7:0] core_dout = 8'h00;
    logic       core_dvld = 1'b0;
    logic [7:0] out_byte;
    logic       out_vld, out_id, job_done, job_err;

    aes_job_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .a_vld(a_vld), .a_key(a_key), .a_din(a_din), .a_rdy(a_rdy),
        .b_vld(b_vld), .b_key(b_key), .b_din(b_din), .b_rdy(b_rdy),
        .core_rst(core_rst), .core_key(core_key), .core_din(core_din),
        .core_dout(core_dout), .core_dvld(core_dvld),
        .out_byte(out_byte), .out_vld(out_vld), .out_id(out_id),
        .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    // Core model state
    logic [7:0] cm_key [16];
    logic [7:0] cm_din [16];
    int cm_ld = 0, cm_wait = 0, cm_out = 0;
    bit cm_en = 1'b1;
    int cm_delay = 40;

    // Core model: load 16 bytes once released from reset, wait, then emit results
    always @(posedge clk) begin
        if (core_rst) begin
            cm_ld <= 0; cm_wait <= 0; cm_out <= 0;
            core_dvld <= 1'b0; core_dout <= 8'h00;
        end else if (cm_ld < 16) begin
            cm_key[cm_ld[3:0]] <= core_key;
            cm_din[cm_ld[3:0]] <= core_din;
            cm_ld <= cm_ld + 1;
        end else if (cm_wait < cm_delay) begin
            cm_wait <= cm_wait + 1;
        end else if (cm_en && cm_out < 16) begin
            core_dvld <= 1'b1;
            core_dout <= cm_key[cm_out[3:0]] ^ 8'hA0;
            cm_out <= cm_out + 1;
        end else begin
            core_dvld <= 1'b0; core_dout <= 8'h00;
        end
    end

    // Requester sources (index 0=A, 1=B) and recorders
    int         s_jobs[2], s_stall_rem[2], s_stall_at[2], s_stall_len[2];
    logic [3:0] s_n[2];
    logic [7:0] s_kb[2], s_db[2];
    bit         s_hs[2], prev_rdy[2];
    logic [7:0] res_byte[64];
    bit         res_id[64];
    int n_res, n_done, n_errp, n_ord, both_rdy, crst_low, done_bad, cyc;
    int rdy_cyc[2], ord[8], ord_cyc[8], done_cyc[8];
    bit err_id;
    int n_cmp = 0, n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        n_res = 0; n_done = 0; n_errp = 0; n_ord = 0; both_rdy = 0;
        crst_low = 0; done_bad = 0; rdy_cyc[0] = 0; rdy_cyc[1] = 0; err_id = 1'b0;
    endtask

    // One clock: record outputs #1 after the edge, then drive the next inputs
    task automatic step();
        bit v[2];
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < 2; r++) begin
            logic rdy_v;
            rdy_v = (r == 0) ? a_rdy : b_rdy;
            if (s_hs[r]) begin
                s_n[r] = s_n[r] + 4'd1;
                if (s_n[r] == 4'd0) s_jobs[r]--;
                if (int'(s_n[r]) == s_stall_at[r]) s_stall_rem[r] = s_stall_len[r];
            end
            if (rdy_v && !prev_rdy[r] && n_ord < 8) begin
                ord[n_ord] = r; ord_cyc[n_ord] = cyc; n_ord++;
            end
            if (rdy_v) rdy_cyc[r]++;
            prev_rdy[r] = rdy_v;
        end
        if (a_rdy && b_rdy) both_rdy++;
        if (!core_rst) crst_low++;
        if (out_vld && n_res < 64) begin
            res_byte[n_res] = out_byte; res_id[n_res] = out_id; n_res++;
        end
        if (job_done) begin
            if (n_done < 8) done_cyc[n_done] = cyc;
            n_done++;
            if (!(out_vld && (n_res % 16 == 0))) done_bad++;
        end
        if (job_err) begin
            n_errp++; err_id = out_id;
            if (out_vld) done_bad++;
        end
        for (int r = 0; r < 2; r++) begin
            v[r] = (s_jobs[r] > 0) && (s_stall_rem[r] == 0);
            if (s_stall_rem[r] > 0) s_stall_rem[r]--;
        end
        a_vld = v[0]; a_key = s_kb[0] + {4'h0, s_n[0]}; a_din = s_db[0] + {4'h0, s_n[0]};
        b_vld = v[1]; b_key = s_kb[1] + {4'h0, s_n[1]}; b_din = s_db[1] + {4'h0, s_n[1]};
        s_hs[0] = a_vld && a_rdy;
        s_hs[1] = b_vld && b_rdy;
    endtask

    task automatic src_init();
        for (int r = 0; r < 2; r++) begin
            s_jobs[r] = 0; s_n[r] = 4'd0; s_stall_rem[r] = 0; s_stall_at[r] = 99;
            s_stall_len[r] = 0; s_hs[r] = 1'b0;
        end
        s_kb[0] = 8'h00; s_db[0] = 8'h10; s_kb[1] = 8'h40; s_db[1] = 8'h50;
    endtask

    task automatic do_reset();
        src_init();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_rec();
    endtask

    task automatic check_job_a(input string tg);
        check({tg, "_nres"}, n_res, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_key%0d", tg, i), 32'(cm_key[i]), i);
            check($sformatf("%s_out%0d", tg, i), 32'(res_byte[i]), 8'hA0 + i);
        end
        check({tg, "_din0"}, 32'(cm_din[0]), 8'h10);
        check({tg, "_din15"}, 32'(cm_din[15]), 8'h1F);
        check({tg, "_id"}, 32'(res_id[15]), 0);
        check({tg, "_done"}, n_done, 1);
        check({tg, "_done_align"}, done_bad, 0);
    endtask

    initial begin
        rst = 1'b1;
        a_vld = 1'b0; b_vld = 1'b0;
        a_key = 8'h00; a_din = 8'h00; b_key = 8'h00; b_din = 8'h00;
        cyc = 0;
        src_init();
        clear_rec();
        prev_rdy[0] = 1'b0; prev_rdy[1] = 1'b0;

        // Reset with A requesting: vld must be ignored while rst is high
        s_jobs[0] = 1;
        step(); step(); step();
        check("rst_a_rdy", 32'(a_rdy), 0);
        check("rst_b_rdy", 32'(b_rdy), 0);
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_core_key", 32'(core_key), 0);
        check("rst_core_din", 32'(core_din), 0);
        check("rst_out_byte", 32'(out_byte), 0);
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_out_id", 32'(out_id), 0);
        check("rst_job_done", 32'(job_done), 0);
        check("rst_job_err", 32'(job_err), 0);

        // Single job on A, no stalls; grant one cycle after vld seen in IDLE
        rst = 1'b0;
        clear_rec();
        step();
        check("t1_grant_latency", 32'(a_rdy), 1);
        for (int i = 0; i < 400 && n_done < 1; i++) step();
        check("t1_fill_len", rdy_cyc[0], 16);
        check("t1_err", n_errp, 0);
        check_job_a("t1");
        for (int i = 0; i < 5; i++) step();
        check("t1_single_done", n_done, 1);
        check("t1_idle_core_rst", 32'(core_rst), 1);
        check("t1_idle_core_key", 32'(core_key), 0);

        // Contention: A and B both requesting; expect A, B, A
        do_reset();
        s_jobs[0] = 2; s_jobs[1] = 1;
        for (int i = 0; i < 800 && n_done < 3; i++) step();
        check("t2_done", n_done, 3);
        check("t2_nord", n_ord, 3);
        check("t2_ord0", ord[0], 0);
        check("t2_ord1", ord[1], 1);
        check("t2_ord2", ord[2], 0);
        check("t2_both_rdy", both_rdy, 0);
        check("t2_rdy_a", rdy_cyc[0], 32);
        check("t2_rdy_b", rdy_cyc[1], 16);
        check("t2_idle_gap", ord_cyc[1] - done_cyc[0], 2);
        check("t2_id0", 32'(res_id[0]), 0);
        check("t2_id16", 32'(res_id[16]), 1);
        check("t2_id32", 32'(res_id[32]), 0);
        check("t2_b_first", 32'(res_byte[16]), 8'hE0);
        check("t2_b_last", 32'(res_byte[31]), 8'hEF);
        check("t2_a2_last", 32'(res_byte[47]), 8'hAF);

        // FILL stall: A drops vld for 5 cycles after byte 7
        do_reset();
        s_jobs[0] = 1; s_stall_at[0] = 8; s_stall_len[0] = 5;
        for (int i = 0; i < 400 && n_done < 1; i++) step();
        check("t3_fill_len", rdy_cyc[0], 21);
        check_job_a("t3");

        // Timeout: core never answers; B pending behind A
        do_reset();
        cm_en = 1'b0;
        s_jobs[0] = 1; s_jobs[1] = 1;
        for (int i = 0; i < 400 && n_errp < 1; i++) step();
        check("t4_err", n_errp, 1);
        check("t4_err_id", 32'(err_id), 0);
        check("t4_no_vld", n_res, 0);
        check("t4_no_done", n_done, 0);
        check("t4_wait_len", crst_low, 16 + TIMEOUT);
        for (int i = 0; i < 5 && n_ord < 2; i++) step();
        check("t4_nord", n_ord, 2);
        check("t4_b_granted", ord[1], 1);

        // Reset during result byte 6, then a fresh A job
        do_reset();
        cm_en = 1'b1;
        s_jobs[0] = 1;
        for (int i = 0; i < 400 && n_res < 7; i++) step();
        check("t5_byte6", 32'(res_byte[6]), 8'hA6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_vld_off", 32'(out_vld), 0);
        check("t5_core_rst", 32'(core_rst), 1);
        check("t5_done_low", 32'(job_done), 0);
        for (int i = 0; i < 30; i++) step();
        check("t5_no_done", n_done, 0);
        check("t5_no_more", n_res, 7);
        clear_rec();
        s_jobs[0] = 1;
        for (int i = 0; i < 400 && n_done < 1; i++) step();
        check_job_a("t5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/aes_job_sched.md
# aes_job_sched

Job scheduler that shares one byte-serial AES-8 core between two requesters, A and B.
- Arbitrates round-robin between the requesters.
- Buffers each job's 16 key bytes and 16 data bytes, then replays them to the core on 16 back-to-back cycles, because the core cannot stall during load.
- Watches the core's done flag, collects 16 result bytes and tags them with the owning requester.
- Sits between the requester-side logic and the AES core, and owns the core's reset.

## Interface
- TIMEOUT, 200: maximum cycles in WAIT before the job is aborted.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock, synchronous and active-high.
- a_vld / b_vld  in  1  requester A/B offers a key/data byte pair.
- a_key, a_din / b_key, b_din  in  8  key byte and data byte, byte 0 first.
- a_rdy / b_rdy  out  1  pair accepted when vld&rdy; high only for the granted requester in FILL.
- core_rst  out  1  reset to the AES core.
- core_key, core_din  out  8  key and data bytes to the core.
- core_dout  in  8  result byte from the core.
- core_dvld  in  1  core output valid.
- out_byte  out  8  result byte.
- out_vld  out  1  result byte valid; no backpressure.
- out_id  out  1  owner of the current result (0=A, 1=B).
- job_done  out  1  1-cycle pulse after the 16th result byte.
- job_err  out  1  1-cycle pulse on timeout; out_id is valid that cycle.

## Operation
- States: IDLE, FILL, CRST, FEED, WAIT, DRAIN.
- IDLE:
  - Grant when a_vld|b_vld.
  - If both request, grant the requester not served last. After reset the last-served pointer = B, so A wins first.
  - Enter FILL with byte counter = 0. The grant is latched for the whole job.
- FILL:
  - rdy of the granted requester = 1.
  - Each handshake writes {key,din} to buffer[cnt] and increments cnt.
  - The requester may stall (vld low) indefinitely.
  - On the 16th handshake (cnt==15 accepted), go to CRST.
  - The other requester's vld is ignored.
- CRST: one cycle; core_rst = 1, guaranteeing a fresh core load phase; go to FEED.
- FEED:
  - core_rst = 0; core_key/core_din = buffer[cnt], cnt 0..15, one byte per cycle, no gaps.
  - After cnt 15, go to WAIT and clear the timeout counter.
- WAIT:
  - Increment the timeout counter each cycle.
  - core_dvld = 1: go to DRAIN, capturing that cycle's core_dout as byte 0.
  - Counter reaches TIMEOUT with no core_dvld: pulse job_err, update the last-served pointer, go to IDLE.
- DRAIN:
  - out_vld = 1 for exactly 16 consecutive cycles; out_byte = core_dout registered; out_id = grant.
  - After the 16th byte, pulse job_done (same cycle as the last out_vld), update the last-served pointer, go to IDLE.
- core_rst = 1 in IDLE, FILL and CRST; 0 in FEED, WAIT and DRAIN.
- core_key/core_din = 0 outside FEED.
- Byte counter is 4 bits, wrap-free: every state exit occurs at cnt==15.
- Timeout counter width = clog2(TIMEOUT+1).

## Timing
- Reset values:
  - state = IDLE, last-served = B.
  - a_rdy = b_rdy = 0, core_rst = 1, core_key = core_din = 0.
  - out_byte = 0, out_vld = 0, out_id = 0.
  - job_done = job_err = 0.
  - Counters = 0.
- Reset mid-job (any state): next cycle is IDLE with the reset values above. The buffer is discarded, no done or err pulse is issued, and an in-flight DRAIN stops immediately.
- Grant latency: a vld seen in IDLE at cycle t gives rdy = 1 at t+1.
- Best-case FILL is 16 cycles; then CRST is 1 cycle and FEED is 16 cycles.
- First core_key/core_din byte appears on the cycle after CRST, with core_rst already low.
- First out_vld appears one cycle after the WAIT cycle that saw core_dvld = 1 (registered output).
- IDLE is visited for one cycle between jobs; back-to-back requests alternate A, B, A, ...
- vld high in the same cycle as rst is ignored.

## Test plan
- Single job on A:
  - Stimulus: A streams key = 0x00..0x0F and din = 0x10..0x1F with no stalls; core model asserts dvld 40 cycles after FEED and emits 0xA0..0xAF.
  - Required: core_key sequence 0x00..0x0F on 16 consecutive cycles; out_byte 0xA0..0xAF with out_id = 0; one job_done pulse.
- Contention:
  - Stimulus: a_vld and b_vld both held high from reset.
  - Required: service order A, B, A; b_rdy = 0 throughout every A FILL.
- FILL stall:
  - Stimulus: A drops vld for 5 cycles after byte 7.
  - Required: 21-cycle FILL; FEED still emits 16 contiguous correct bytes.
- Timeout:
  - Stimulus: TIMEOUT = 200; core_dvld is never asserted.
  - Required: job_err pulse with out_id = 0; out_vld never set; next pending B job is granted.
- Reset in DRAIN:
  - Stimulus: rst during result byte 6.
  - Required: out_vld = 0 on the next cycle; no job_done; core_rst = 1; a subsequent fresh A job completes correctly.
